// File: rtl/ep_tok_arb_pkg.sv
// Shared types, defaults and helpers for the endpoint token arbiter.
package ep_arb_pkg;

  localparam int DEF_NUM_CHN    = 2;
  localparam int DEF_OFFER_TO   = 8;
  localparam int DEF_MAX_HOLD   = 4096;
  localparam int DEF_GAP_CYCLES = 1;

  typedef enum logic [1:0] {
    ST_GAP   = 2'd0,
    ST_OFFER = 2'd1,
    ST_BUSY  = 2'd2
  } arb_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ep_tok_arb_if.sv
// Token handshake and monitored TRN tx bus between the arbiter and its channels.
interface ep_tok_arb_if #(
  parameter int NUM_CHN = ep_arb_pkg::DEF_NUM_CHN
) ();

  // Handshake: chn_trn[i] offers the token to channel i; the channel takes it by
  // raising chn_drvn[i] and keeps it high while driving TRN tx. A TRN beat is
  // accepted in a cycle where trn_tsrc_rdy_n and trn_tdst_rdy_n are both low.
  logic [NUM_CHN-1:0] chn_reqep;
  logic [NUM_CHN-1:0] chn_drvn;
  logic [NUM_CHN-1:0] chn_trn;
  logic               trn_tsof_n;
  logic               trn_teof_n;
  logic               trn_tsrc_rdy_n;
  logic               trn_tdst_rdy_n;

  modport master (
    input  chn_reqep, chn_drvn,
    input  trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tdst_rdy_n,
    output chn_trn
  );

  modport slave (
    output chn_reqep, chn_drvn,
    output trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tdst_rdy_n,
    input  chn_trn
  );

endinterface

// File: rtl/ep_tok_arb_rr_pick.sv
// Combinational round-robin search: first requesting channel after 'last'.
module rr_pick
  import ep_arb_pkg::*;
#(
  parameter int NUM_CHN = DEF_NUM_CHN,
  parameter int IDX_W   = clog2(NUM_CHN)
) (
  input  logic [NUM_CHN-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [IDX_W-1:0]   sel,
  output logic               any_req
);

  logic found;
  int   idx;

  // sel is only meaningful while any_req is set.
  always_comb begin
    sel     = '0;
    any_req = |req;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NUM_CHN; k++) begin
      idx = int'(last) + k;
      if (idx >= NUM_CHN) idx = idx - NUM_CHN;
      if (!found && req[IDX_W'(idx)]) begin
        sel   = IDX_W'(idx);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ep_tok_arb.sv
// Endpoint token arbiter: hands one TRN-tx token among channels, switching
// owners only at TLP boundaries, with sticky hold/protocol error flags.
module ep_tok_arb
  import ep_arb_pkg::*;
#(
  parameter int NUM_CHN    = DEF_NUM_CHN,
  parameter int OFFER_TO   = DEF_OFFER_TO,
  parameter int MAX_HOLD   = DEF_MAX_HOLD,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int IDX_W      = clog2(NUM_CHN)
) (
  input  logic              clk,
  input  logic              rst_n,
  ep_tok_arb_if.master      bus,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              arb_busy,
  output logic              err_hold,
  output logic              err_proto,
  output arb_state_t        state_dbg
);

  localparam int GAP_W  = clog2(GAP_CYCLES) + 1;
  localparam int OFF_W  = clog2(OFFER_TO) + 1;
  localparam int HOLD_W = clog2(MAX_HOLD) + 1;

  arb_state_t         state_q, state_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [OFF_W-1:0]   offer_cnt_q, offer_cnt_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic [NUM_CHN-1:0] chn_trn_q, chn_trn_d;
  logic               arb_busy_q, arb_busy_d;
  logic               err_hold_q, err_hold_d;
  logic               err_proto_q, err_proto_d;
  logic               pkt_open_q, pkt_open_d;

  logic               beat_acc, sof_acc, drv_sel;
  logic [NUM_CHN-1:0] holder_mask;
  logic [IDX_W-1:0]   req_sel, poll_sel, pick;
  logic               any_req;

  rr_pick #(.NUM_CHN(NUM_CHN), .IDX_W(IDX_W)) u_rr_pick (
    .req     (bus.chn_reqep),
    .last    (last_q),
    .sel     (req_sel),
    .any_req (any_req)
  );

  assign beat_acc    = !bus.trn_tsrc_rdy_n && !bus.trn_tdst_rdy_n;
  assign sof_acc     = beat_acc && !bus.trn_tsof_n;
  assign drv_sel     = bus.chn_drvn[grant_idx_q];
  assign holder_mask = NUM_CHN'(1) << grant_idx_q;
  assign poll_sel    = (last_q == IDX_W'(NUM_CHN - 1)) ? '0 : last_q + 1'b1;
  assign pick        = any_req ? req_sel : poll_sel;

  // An eof beat wins over sof so a single-beat TLP leaves the tracker closed.
  always_comb begin
    pkt_open_d = pkt_open_q;
    if (beat_acc && !bus.trn_teof_n)     pkt_open_d = 1'b0;
    else if (sof_acc && bus.trn_teof_n)  pkt_open_d = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    gap_cnt_d   = gap_cnt_q;
    offer_cnt_d = offer_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    last_d      = last_q;
    grant_idx_d = grant_idx_q;
    chn_trn_d   = chn_trn_q;
    err_hold_d  = err_hold_q;
    err_proto_d = err_proto_q | (|(bus.chn_drvn & ~holder_mask));
    unique case (state_q)
      ST_GAP: begin
        if (gap_cnt_q >= GAP_W'(GAP_CYCLES - 1)) begin
          state_d     = ST_OFFER;
          grant_idx_d = pick;
          chn_trn_d   = NUM_CHN'(1) << pick;
          offer_cnt_d = '0;
          gap_cnt_d   = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      ST_OFFER: begin
        if (drv_sel) begin
          state_d    = ST_BUSY;
          hold_cnt_d = '0;
        end else if (offer_cnt_q >= OFF_W'(OFFER_TO - 1)) begin
          state_d   = ST_GAP;
          chn_trn_d = '0;
          last_d    = grant_idx_q;
          gap_cnt_d = '0;
        end else begin
          offer_cnt_d = offer_cnt_q + 1'b1;
        end
      end
      ST_BUSY: begin
        if (!(&hold_cnt_q)) hold_cnt_d = hold_cnt_q + 1'b1;
        // Overlong hold is only reported; the holder keeps the token.
        if (hold_cnt_d >= HOLD_W'(MAX_HOLD)) err_hold_d = 1'b1;
        if (!drv_sel && pkt_open_q) err_proto_d = 1'b1;
        if (!drv_sel && !pkt_open_q && !sof_acc) begin
          state_d   = ST_GAP;
          chn_trn_d = '0;
          last_d    = grant_idx_q;
          gap_cnt_d = '0;
        end
      end
      default: begin
        state_d   = ST_GAP;
        chn_trn_d = '0;
        gap_cnt_d = '0;
      end
    endcase
    arb_busy_d = |chn_trn_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_GAP;
      gap_cnt_q   <= '0;
      offer_cnt_q <= '0;
      hold_cnt_q  <= '0;
      last_q      <= IDX_W'(NUM_CHN - 1);
      grant_idx_q <= '0;
      chn_trn_q   <= '0;
      arb_busy_q  <= 1'b0;
      err_hold_q  <= 1'b0;
      err_proto_q <= 1'b0;
      pkt_open_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      offer_cnt_q <= offer_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      last_q      <= last_d;
      grant_idx_q <= grant_idx_d;
      chn_trn_q   <= chn_trn_d;
      arb_busy_q  <= arb_busy_d;
      err_hold_q  <= err_hold_d;
      err_proto_q <= err_proto_d;
      pkt_open_q  <= pkt_open_d;
    end
  end

  assign bus.chn_trn = chn_trn_q;
  assign grant_idx   = grant_idx_q;
  assign arb_busy    = arb_busy_q;
  assign err_hold    = err_hold_q;
  assign err_proto   = err_proto_q;
  assign state_dbg   = state_q;

endmodule

// File: doc/ep_tok_arb.md
Name: ep_tok_arb

Overview:
- Top-level endpoint token arbiter: the granting end of the per-channel chn_trn / chn_drvn / chn_reqep handshake.
- Passes a single "your turn" token among NUM_CHN channel instances that share one PCIe TRN transmit interface.
- Each channel ORs its TRN tx outputs onto a common bus. This block guarantees that only one channel ever holds the token, and that handover happens only at a TLP boundary.

Parameters:
- NUM_CHN, 2, number of channels arbitrated (2..8)
- OFFER_TO, 8, cycles a token is offered without chn_drvn before it is withdrawn (>=2)
- MAX_HOLD, 4096, cycles of continuous chn_drvn before err_hold is flagged
- GAP_CYCLES, 1, idle cycles with no token asserted between grants (>=1)

Ports:
- clk  in  1  PCIe user clock; the block's only clock
- rst_n  in  1  asynchronous, active-low reset
- chn_reqep  in  NUM_CHN  per-channel urgent request for the endpoint
- chn_drvn  in  NUM_CHN  per-channel "currently driving TRN tx"
- chn_trn  out  NUM_CHN  per-channel token, one-hot or zero
- trn_tsof_n  in  1  monitored TRN tx start-of-frame (combined bus)
- trn_teof_n  in  1  monitored TRN tx end-of-frame
- trn_tsrc_rdy_n  in  1  monitored TRN tx source ready
- trn_tdst_rdy_n  in  1  monitored TRN tx destination ready
- grant_idx  out  clog2(NUM_CHN)  index of the current or last token holder
- arb_busy  out  1  token currently asserted
- err_hold  out  1  sticky: holder exceeded MAX_HOLD
- err_proto  out  1  sticky: holder dropped chn_drvn mid-TLP, or chn_drvn seen from a non-holder

Behaviour:
- Reset (async, rst_n=0):
  - chn_trn=0, arb_busy=0, err_*=0, grant_idx=0, state=GAP.
  - Round-robin pointer last=NUM_CHN-1, so the first grant goes to channel 0.
  - Gap counter preloaded so the first offer occurs GAP_CYCLES after reset release.
- All outputs are registered. chn_trn is one-hot or zero in every cycle.
- Beat accepted: tsrc_rdy_n=0 and tdst_rdy_n=0.
- pkt_open tracker:
  - Set on an accepted beat with tsof_n=0 and teof_n=1.
  - Cleared on an accepted beat with teof_n=0.
  - A single-beat TLP (sof and eof together) leaves it 0.
- Selection:
  - If any chn_reqep is set, pick the first requesting channel after last, modulo NUM_CHN.
  - Otherwise pick last+1 (polled rotation), so every channel gets a turn even without requests.
- States:
  - GAP: chn_trn=0; count GAP_CYCLES. On expiry: compute sel, load grant_idx, drive chn_trn[sel]=1 from the next cycle, clear the offer counter, go to OFFER.
  - OFFER: token held.
    - chn_drvn[sel]=1 -> BUSY, clear hold counter.
    - Offer counter reaches OFFER_TO-1 with chn_drvn[sel]=0 -> drop token, last=sel, go to GAP.
  - BUSY: token held; hold counter increments each cycle, saturating.
    - Counter reaching MAX_HOLD sets err_hold. There is no preemption: the token stays.
    - Exit only when chn_drvn[sel]=0 AND pkt_open=0 AND no accepted sof in this cycle. On exit: token dropped next cycle, last=sel, go to GAP.
    - chn_drvn[sel] falling while pkt_open=1 sets err_proto; the token is held until pkt_open clears.
- chn_drvn[j]=1 for any j other than sel in any state sets err_proto. It is otherwise ignored.
- A chn_reqep change during OFFER or BUSY has no effect until the next GAP expiry.
- Counter widths are clog2 of their limit plus 1, and all counters saturate.
- err_* bits clear only on reset.
- Reset mid-TLP: the token drops immediately (async) and pkt_open clears.

Decomposition:
- Shared package ep_arb_pkg:
  - state encoding constants (GAP, OFFER, BUSY)
  - clog2 function
  - default parameter constants
- One natural sub-module, rr_pick: combinational round-robin next-index selector.
  - Inputs: req vector, last index.
  - Outputs: sel index, any_req.
  - Instantiated once.

Test Plan:
- NUM_CHN=2, no reqep, chn_drvn never asserted:
  - chn_trn toggles 01 -> 00 -> 10 -> 00.
  - Each offer lasts 8 cycles with a 1-cycle gap.
  - err_*=0.
- Channel 1 asserts reqep while channel 0 is in OFFER:
  - Channel 0 times out after 8 cycles.
  - After the gap, chn_trn=10 and grant_idx=1.
- Channel 0 takes the token and sends a 4-beat TLP (drvn high 6 cycles), with tdst_rdy_n stalled 2 cycles mid-packet:
  - Token held throughout.
  - Released 1 cycle after drvn falls.
  - Next grant goes to channel 1.
- Holder drops chn_drvn after the sof beat but before eof:
  - err_proto=1.
  - Token held until the eof beat is accepted, then released.
- MAX_HOLD=16, holder keeps drvn high for 20 cycles:
  - err_hold=1 at cycle 16.
  - Token not revoked.
- rst_n asserted while BUSY mid-packet:
  - chn_trn=0 in the same cycle (asynchronous).
  - After release, the first grant goes to channel 0 after GAP_CYCLES.
